// File: rtl/quad_encoder_counter_if.sv
// Pin/bus bundle for one quadrature-encoder axis.
//
// master: the side that drives the encoder pins and control strobes (register block / bench)
// slave : the quad_encoder_counter itself
//
// Signals
//   enc_a, enc_b, enc_z  encoder A/B/index pins, asynchronous to the counter clock
//   mode                 00 x1, 01 x2, 10/11 x4
//   load, load_value     1-cycle preload strobe and value
//   index_en             enable capture on Z rising edge
//   index_zero           on a captured Z edge also reset the count to its initial value
//   err_clr              clears the sticky illegal-transition flag
//   count, dir, err      position, direction of last counted step, sticky error
//   index_count          count value at the last captured Z edge
//   index_valid          1-cycle pulse when index_count is updated
interface quad_encoder_counter_if #(
  parameter int unsigned WIDTH = 32
);

  logic             enc_a;
  logic             enc_b;
  logic             enc_z;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             index_en;
  logic             index_zero;
  logic             err_clr;

  logic [WIDTH-1:0] count;
  logic             dir;
  logic             err;
  logic [WIDTH-1:0] index_count;
  logic             index_valid;

  modport master (
    output enc_a, enc_b, enc_z, mode, load, load_value, index_en, index_zero, err_clr,
    input  count, dir, err, index_count, index_valid
  );

  modport slave (
    input  enc_a, enc_b, enc_z, mode, load, load_value, index_en, index_zero, err_clr,
    output count, dir, err, index_count, index_valid
  );

endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder / position counter for one encoder axis.
//
// Pins are double-flop synchronised, then each passes through a glitch filter that only accepts
// a new level after it has been seen for FILTER_LEN consecutive cycles. The filtered A/B state is
// compared against the previous cycle's state to derive a step (x1/x2/x4 selectable at runtime);
// simultaneous A and B changes are flagged as illegal. A rising edge on filtered Z can capture
// the count and optionally re-initialise it. A preload strobe overrides everything but reset.
//
// Ports
//   clk50    system clock, all logic on posedge
//   reset_n  synchronous active-low reset
//   bus      quad_encoder_counter_if.slave (encoder pins, control strobes, status outputs)
//
// Parameters
//   WIDTH       counter / load / capture width (>= 8)
//   FILTER_LEN  cycles a synced input must hold a new level before accepted (>= 1)
//   CNT_INIT    count after reset and on index zeroing
module quad_encoder_counter #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] CNT_INIT   = {1'b0, {(WIDTH-1){1'b1}}}
) (
  input logic                   clk50,
  input logic                   reset_n,
  quad_encoder_counter_if.slave bus
);

  localparam int unsigned      HoldW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned      PrimeLen = FILTER_LEN + 2;
  localparam int unsigned      PrimeW   = $clog2(PrimeLen + 1);
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(FILTER_LEN - 1);
  localparam logic [PrimeW-1:0] PrimeEnd = PrimeW'(PrimeLen);
  localparam logic [WIDTH-1:0]  One      = WIDTH'(1);

  // Bit positions inside the 3-bit pin vectors.
  localparam int unsigned IdxB = 0;
  localparam int unsigned IdxA = 1;
  localparam int unsigned IdxZ = 2;

  logic [2:0] pins;

  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][HoldW-1:0] hold_q, hold_d;
  logic [2:0]            prev_q, prev_d;
  logic [PrimeW-1:0]     prime_q, prime_d;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] idx_cnt_q, idx_cnt_d;
  logic             idx_vld_q, idx_vld_d;

  logic             priming;
  logic             eval;
  logic [1:0]       cur_ab, prev_ab;
  logic             chg_a, chg_b;
  logic             illegal;
  logic             step_en, step_up;
  logic             z_rise;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] count_pre;

  assign pins = {bus.enc_z, bus.enc_a, bus.enc_b};

  // While priming, the filters and prev state load straight from the synchroniser so that the
  // pin levels present at reset release never look like a transition.
  assign priming = (prime_q != PrimeEnd);
  assign eval    = ~priming;

  always_comb begin
    prime_d = prime_q;
    if (priming) begin
      prime_d = prime_q + PrimeW'(1);
    end
  end

  // Glitch filter: a level is accepted on the FILTER_LEN-th consecutive cycle it differs from
  // the filtered value; any return to the filtered level restarts the hold count.
  always_comb begin
    filt_d = filt_q;
    hold_d = hold_q;
    if (priming) begin
      filt_d = sync2_q;
      hold_d = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (hold_q[i] == HoldMax) begin
            filt_d[i] = sync2_q[i];
            hold_d[i] = '0;
          end else begin
            hold_d[i] = hold_q[i] + HoldW'(1);
          end
        end else begin
          hold_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    prev_d = filt_q;
    if (priming) begin
      prev_d = filt_d;
    end
  end

  // Step decode. Forward sequence is 00 -> 10 -> 11 -> 01 -> 00 ({A,B}).
  // An A edge is forward when the new A differs from B; a B edge is forward when they match.
  assign cur_ab  = {filt_q[IdxA], filt_q[IdxB]};
  assign prev_ab = {prev_q[IdxA], prev_q[IdxB]};
  assign chg_a   = cur_ab[1] ^ prev_ab[1];
  assign chg_b   = cur_ab[0] ^ prev_ab[0];
  assign illegal = eval & chg_a & chg_b;

  always_comb begin
    step_en = 1'b0;
    step_up = 1'b0;
    case (bus.mode)
      2'b00: begin
        // x1: only the A edge with B low counts (00 <-> 10).
        step_en = chg_a & ~chg_b & ~cur_ab[0];
        step_up = cur_ab[1];
      end
      2'b01: begin
        // x2: A edges only.
        step_en = chg_a & ~chg_b;
        step_up = cur_ab[1] ^ cur_ab[0];
      end
      default: begin
        // x4: every legal single-bit change.
        step_en = chg_a ^ chg_b;
        step_up = chg_a ? (cur_ab[1] ^ cur_ab[0]) : ~(cur_ab[1] ^ cur_ab[0]);
      end
    endcase
    step_en = step_en & eval;
  end

  assign z_rise = eval & bus.index_en & filt_q[IdxZ] & ~prev_q[IdxZ];

  // count_pre is the value this cycle would end with ignoring index zeroing; it is also what
  // gets captured on an index edge.
  always_comb begin
    count_step = count_q;
    if (step_en) begin
      count_step = step_up ? (count_q + One) : (count_q - One);
    end
    count_pre = bus.load ? bus.load_value : count_step;
  end

  always_comb begin
    count_d   = count_pre;
    dir_d     = dir_q;
    err_d     = err_q;
    idx_cnt_d = idx_cnt_q;
    idx_vld_d = 1'b0;

    if (!bus.load && z_rise && bus.index_zero) begin
      count_d = CNT_INIT;
    end

    if (step_en) begin
      dir_d = step_up;
    end

    // Set wins over clear.
    if (illegal) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end

    if (z_rise) begin
      idx_cnt_d = count_pre;
      idx_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      hold_q    <= '0;
      prev_q    <= '0;
      prime_q   <= '0;
      count_q   <= CNT_INIT;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      idx_cnt_q <= '0;
      idx_vld_q <= 1'b0;
    end else begin
      sync1_q   <= pins;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      prev_q    <= prev_d;
      prime_q   <= prime_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      idx_cnt_q <= idx_cnt_d;
      idx_vld_q <= idx_vld_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.dir         = dir_q;
  assign bus.err         = err_q;
  assign bus.index_count = idx_cnt_q;
  assign bus.index_valid = idx_vld_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter. A 32-bit and an 8-bit instance (FILTER_LEN=4) share
// the same stimulus; the 8-bit one is checked where narrow wrap-around matters.
module tb_quad_encoder_counter;

  localparam logic [31:0] Init32 = 32'h7FFF_FFFF;
  localparam int          Settle = 8;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        enc_a, enc_b, enc_z;
  logic [1:0]  mode;
  logic        load;
  logic [31:0] load_value;
  logic        index_en, index_zero, err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk50 = ~clk50;

  quad_encoder_counter_if #(.WIDTH(32)) if32 ();
  quad_encoder_counter_if #(.WIDTH(8))  if8  ();

  assign if32.enc_a      = enc_a;
  assign if32.enc_b      = enc_b;
  assign if32.enc_z      = enc_z;
  assign if32.mode       = mode;
  assign if32.load       = load;
  assign if32.load_value = load_value;
  assign if32.index_en   = index_en;
  assign if32.index_zero = index_zero;
  assign if32.err_clr    = err_clr;

  assign if8.enc_a      = enc_a;
  assign if8.enc_b      = enc_b;
  assign if8.enc_z      = enc_z;
  assign if8.mode       = mode;
  assign if8.load       = load;
  assign if8.load_value = load_value[7:0];
  assign if8.index_en   = index_en;
  assign if8.index_zero = index_zero;
  assign if8.err_clr    = err_clr;

  quad_encoder_counter #(.WIDTH(32), .FILTER_LEN(4)) u_dut32 (
    .clk50  (clk50),
    .reset_n(reset_n),
    .bus    (if32)
  );

  quad_encoder_counter #(.WIDTH(8), .FILTER_LEN(4)) u_dut8 (
    .clk50  (clk50),
    .reset_n(reset_n),
    .bus    (if8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    {enc_a, enc_b} = ab;
    cycles(Settle);
  endtask

  task automatic do_load(input logic [31:0] v);
    load       = 1'b1;
    load_value = v;
    cycles(1);
    load       = 1'b0;
  endtask

  task automatic fwd_cycle();
    set_ab(2'b10);
    set_ab(2'b11);
    set_ab(2'b01);
    set_ab(2'b00);
  endtask

  task automatic rev_cycle();
    set_ab(2'b01);
    set_ab(2'b11);
    set_ab(2'b10);
    set_ab(2'b00);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(10);
  endtask

  initial begin
    reset_n    = 1'b0;
    enc_a      = 1'b0;
    enc_b      = 1'b0;
    enc_z      = 1'b0;
    mode       = 2'b00;
    load       = 1'b0;
    load_value = '0;
    index_en   = 1'b0;
    index_zero = 1'b0;
    err_clr    = 1'b0;
    cycles(3);

    // Reset state
    check("rst_count", if32.count, Init32);
    check("rst_count8", if8.count, 8'h7F);
    check("rst_dir", if32.dir, 0);
    check("rst_err", if32.err, 0);
    check("rst_idx_cnt", if32.index_count, 0);
    check("rst_idx_vld", if32.index_valid, 0);
    reset_n = 1'b1;
    cycles(10);
    check("prime_count", if32.count, Init32);

    // x1, four forward cycles
    for (int i = 0; i < 4; i++) fwd_cycle();
    check("x1_count", if32.count, 32'h8000_0003);
    check("x1_dir", if32.dir, 1);
    check("x1_err", if32.err, 0);

    // Reset while an A edge is still in the filter: no count after re-priming
    enc_a = 1'b1;
    cycles(3);
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(12);
    check("midrst_count", if32.count, Init32);
    check("midrst_dir", if32.dir, 0);
    enc_a = 1'b0;
    do_reset();

    // x4 / x2 reverse, x2 forward
    mode = 2'b10;
    cycles(3);
    check("mode_chg_count", if32.count, Init32);
    rev_cycle();
    check("x4_rev_count", if32.count, 32'h7FFF_FFFB);
    check("x4_rev_dir", if32.dir, 0);
    do_load(Init32);
    mode = 2'b01;
    rev_cycle();
    check("x2_rev_count", if32.count, 32'h7FFF_FFFD);
    check("x2_rev_dir", if32.dir, 0);
    fwd_cycle();
    check("x2_fwd_count", if32.count, Init32);
    check("x2_fwd_dir", if32.dir, 1);

    // Wrap-around in both directions
    mode = 2'b10;
    do_load(32'h0000_00FF);
    check("load_count8", if8.count, 8'hFF);
    set_ab(2'b10);
    check("wrap_up8", if8.count, 8'h00);
    check("wrap_up32", if32.count, 32'h0000_0100);
    do_load(32'h0);
    set_ab(2'b00);
    check("wrap_dn8", if8.count, 8'hFF);
    check("wrap_dn32", if32.count, 32'hFFFF_FFFF);
    check("wrap_dn_dir", if32.dir, 0);

    // Glitch rejection and latency
    do_load(32'h10);
    enc_a = 1'b1;
    cycles(3);
    enc_a = 1'b0;
    cycles(10);
    check("glitch_count", if32.count, 32'h10);
    enc_a = 1'b1;
    cycles(6);
    check("lat_before", if32.count, 32'h10);
    cycles(1);
    check("lat_at", if32.count, 32'h11);
    check("lat_dir", if32.dir, 1);

    // Illegal transitions and err_clr
    set_ab(2'b00);
    check("back_count", if32.count, 32'h10);
    {enc_a, enc_b} = 2'b11;
    cycles(10);
    check("illegal_err", if32.err, 1);
    check("illegal_count", if32.count, 32'h10);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_clr", if32.err, 0);
    {enc_a, enc_b} = 2'b00;
    cycles(6);
    check("err_pre_illegal", if32.err, 0);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_set_wins", if32.err, 1);
    check("err_set_count", if32.count, 32'h10);
    cycles(3);

    // Index capture with zeroing on a forward step
    do_load(32'h100);
    index_en   = 1'b1;
    index_zero = 1'b1;
    enc_a      = 1'b1;
    enc_z      = 1'b1;
    cycles(6);
    check("idx_vld_before", if32.index_valid, 0);
    cycles(1);
    check("idx_vld", if32.index_valid, 1);
    check("idx_cnt", if32.index_count, 32'h101);
    check("idx_zero_count", if32.count, Init32);
    cycles(1);
    check("idx_vld_pulse", if32.index_valid, 0);
    check("idx_after_count", if32.count, Init32);

    // Load beats index zeroing; capture takes the loaded value
    enc_z = 1'b0;
    cycles(10);
    enc_b = 1'b1;
    enc_z = 1'b1;
    cycles(6);
    load       = 1'b1;
    load_value = 32'h555;
    cycles(1);
    load       = 1'b0;
    check("idx_load_count", if32.count, 32'h555);
    check("idx_load_cnt", if32.index_count, 32'h555);
    check("idx_load_vld", if32.index_valid, 1);

    // Z edge ignored when index_en is low
    enc_z = 1'b0;
    cycles(10);
    index_en = 1'b0;
    load_value = 32'h0;
    enc_z = 1'b1;
    cycles(10);
    check("idx_dis_cnt", if32.index_count, 32'h555);
    check("idx_dis_count", if32.count, 32'h555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
